lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Receiving end of the team's 4-chip graphic LCD write bus: db, d/i, cs[3:0], en, rw, rst.
- Decodes every bus transfer exactly as a KS0108-style controller does: display on/off, set Y, set page, set start line, and data write with Y auto-increment.
- Stores pixels in a 2048-byte shadow display RAM with a registered readback port.
- Serves as a synthesizable panel stand-in for the driver bench and as a mirror source for alternate display outputs.

Parameters:
- CLEAR_VAL, 8'h00, byte written to every RAM location during the power-on clear sweep.
- CLEAR_ON_RESET, 1, when 1 rstn triggers a full RAM sweep; when 0 RAM content is retained across rstn.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- db_i  in  8  bus data/instruction byte.
- dori_i  in  1  1 = data, 0 = instruction.
- cs_i  in  4  chip selects, one per 64x64 chip; chip index = bit index.
- en_i  in  1  bus enable strobe.
- rw_i  in  1  0 = write, 1 = read (unsupported).
- rst_i  in  1  bus-side panel reset, active high.
- rd_addr_i  in  11  readback address {chip[1:0], page[2:0], col[5:0]}.
- rd_data_o  out  8  readback byte.
- disp_on_o  out  4  per-chip display-on flag.
- start_line_o  out  24  per-chip start line, 6 bits each; chip0 in [5:0].
- busy_o  out  1  RAM clear sweep in progress.
- err_o  out  1  sticky protocol error.
- show_o  out  1  one-cycle pulse on each committed display-on command.

Behaviour:
- Input stage: all bus inputs registered once (same clock domain, no CDC).
- Edge detect: en_edge = en_r & ~en_rr. A transfer commits on the clock edge after en_edge is detected, using the registered db/dori/cs/rw.
- Latency: 2 clk edges from the first edge that samples en_i=1 to the register/RAM update.
- Readback: rd_data_o is registered, 1-cycle latency. On a same-cycle read/write address collision it returns the old (pre-write) byte.
- Top FSM states: CLEAR, RUN.
  - rstn low forces CLEAR (when CLEAR_ON_RESET=1) or RUN (when 0).
  - CLEAR writes CLEAR_VAL to addresses 0..2047, one per cycle, with busy_o=1, then moves to RUN.
- Reset values:
  - rd_data_o=0, disp_on_o=0, start_line_o=0, err_o=0, show_o=0.
  - busy_o=CLEAR_ON_RESET.
  - All per-chip Y=0, page=0.
- Instruction decode (dori=0, rw=0), applied to every chip whose cs bit is set:
  - 0011_111d: disp_on=d. show_o pulses when d=1.
  - 01yyyyyy: Y=y.
  - 10111ppp: page=p.
  - 11zzzzzz: start_line=z.
  - Any other code: ignored, no error.
- Data write (dori=1, rw=0):
  - Exactly one cs set: RAM[{chip,page,Y}] <= db, then that chip's Y <= Y+1, wrapping 63->0. Page never auto-increments.
  - More than one cs set: write only the lowest-index selected chip, advance only its Y, set err_o.
- cs_i=0: transfer ignored, no error.
- rw=1: transfer ignored, err_o set.
- Transfer committing during CLEAR: dropped, err_o set.
- rst_i high (registered): all chips get disp_on=0, Y=0, page=0, start_line=0. RAM is untouched. Any transfer committing in the same cycle is dropped without error.
- rstn asserted mid-sweep: the sweep restarts at address 0.
- err_o clears only on rstn.

Decomposition:
- Package lcd_bus_pkg:
  - Opcode match masks/values: CMD_DISP, CMD_SETY, CMD_PAGE, CMD_START.
  - Field widths: COL_W=6, PAGE_W=3, CHIP_W=2.
  - Readback address packing function.
- Sub-module lcd_chip_regs, instantiated 4x: holds Y, page, disp_on, start_line; takes a decoded command/strobe and returns the current write address.
- RAM is an inferred 2048x8 simple dual-port array in the top.

Test Plan:
- rstn low 1 cycle -> busy_o high for exactly 2048 cycles; after it drops, every rd_addr returns 8'h00; disp_on_o=4'h0.
- cs=4'b0001 transfers 0x3E, 0x45, 0xBA, data 0xA5 -> RAM[{2'd0,3'd2,6'd5}]=0xA5, readable 1 cycle after rd_addr; chip0 Y=6.
- cs=4'b1000, Y=63 via 0x7F, data 0x11 then 0x22 -> RAM[{3,p,63}]=0x11, RAM[{3,p,0}]=0x22 (wrap, page unchanged).
- Full driver frame: 4 chips x 8 pages x 64 columns, then 0x3F -> readback matches the source image byte-for-byte; show_o pulses once; disp_on_o=4'hF.
- cs=4'b0110 with data 0x5A -> only chip1 written, chip2 Y unchanged, err_o=1. Separately, rw=1 -> ignored, err_o=1.
- rst_i pulse after a write to chip2 -> disp_on/Y/page/start cleared, RAM byte still readable; a transfer committing in the rst_i cycle is dropped.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared field widths, opcode patterns and helpers for the LCD write-bus receiver.
// Pure declarations: no latency, no flow control.
package lcd_bus_pkg;

  localparam int COL_W     = 6;
  localparam int PAGE_W    = 3;
  localparam int CHIP_W    = 2;
  localparam int NCHIP     = 1 << CHIP_W;
  localparam int ADDR_W    = CHIP_W + PAGE_W + COL_W;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  localparam logic [7:0] CMD_DISP_MASK  = 8'hFE;
  localparam logic [7:0] CMD_DISP       = 8'h3E;
  localparam logic [7:0] CMD_SETY_MASK  = 8'hC0;
  localparam logic [7:0] CMD_SETY       = 8'h40;
  localparam logic [7:0] CMD_PAGE_MASK  = 8'hF8;
  localparam logic [7:0] CMD_PAGE       = 8'hB8;
  localparam logic [7:0] CMD_START_MASK = 8'hC0;
  localparam logic [7:0] CMD_START      = 8'hC0;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_DISP,
    OP_SETY,
    OP_PAGE,
    OP_START,
    OP_INC
  } chip_op_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [CHIP_W-1:0] chip,
                                                  input logic [PAGE_W-1:0] page,
                                                  input logic [COL_W-1:0]  col);
    return {chip, page, col};
  endfunction

  function automatic chip_op_e decode_instr(input logic [7:0] code);
    chip_op_e op;
    op = OP_NONE;
    if ((code & CMD_DISP_MASK) == CMD_DISP)         op = OP_DISP;
    else if ((code & CMD_SETY_MASK) == CMD_SETY)    op = OP_SETY;
    else if ((code & CMD_PAGE_MASK) == CMD_PAGE)    op = OP_PAGE;
    else if ((code & CMD_START_MASK) == CMD_START)  op = OP_START;
    return op;
  endfunction

endpackage

// File: rtl/lcd_chip_regs.sv
// Per-chip controller registers (Y, page, display-on, start line); ops apply on the next clk.
// Always accepts its op strobe; no backpressure.
module lcd_chip_regs
  import lcd_bus_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_rst,
  input  chip_op_e                  i_op,
  input  logic [COL_W-1:0]          i_arg,
  output logic                      o_disp_on,
  output logic [COL_W-1:0]          o_start_line,
  output logic [PAGE_W+COL_W-1:0]   o_wr_addr
);

  logic              r_disp_on;
  logic [COL_W-1:0]  r_start;
  logic [COL_W-1:0]  r_y;
  logic [PAGE_W-1:0] r_page;

  // Panel reset wins over any op arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn || i_rst) begin
      r_disp_on <= 1'b0;
      r_start   <= '0;
      r_y       <= '0;
      r_page    <= '0;
    end else begin
      case (i_op)
        OP_DISP:  r_disp_on <= i_arg[0];
        OP_SETY:  r_y       <= i_arg;
        OP_PAGE:  r_page    <= i_arg[PAGE_W-1:0];
        OP_START: r_start   <= i_arg;
        OP_INC:   r_y       <= r_y + COL_W'(1);
        default:  ;
      endcase
    end
  end

  assign o_disp_on    = r_disp_on;
  assign o_start_line = r_start;
  assign o_wr_addr    = {r_page, r_y};

endmodule

// File: rtl/lcd_bus_receiver.sv
// KS0108-style 4-chip LCD bus receiver with 2048-byte shadow RAM; commit 2 clk after en_i seen high,
// readback 1 clk. The bus has no backpressure: transfers arriving during the clear sweep are dropped.
module lcd_bus_receiver
  import lcd_bus_pkg::*;
#(
  parameter logic [7:0] CLEAR_VAL      = 8'h00,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              db_i,
  input  logic                    dori_i,
  input  logic [NCHIP-1:0]        cs_i,
  input  logic                    en_i,
  input  logic                    rw_i,
  input  logic                    rst_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [7:0]              rd_data_o,
  output logic [NCHIP-1:0]        disp_on_o,
  output logic [NCHIP*COL_W-1:0]  start_line_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic                    show_o
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e             r_state;
  logic [7:0]         r_db;
  logic               r_dori;
  logic [NCHIP-1:0]   r_cs;
  logic               r_en;
  logic               r_en_d;
  logic               r_rw;
  logic               r_rst;
  logic               r_busy;
  logic               r_err;
  logic               r_show;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic [7:0]         r_rd_data;
  logic [7:0]         r_mem [RAM_DEPTH];

  logic                    w_commit;
  logic                    w_run;
  logic                    w_live;
  logic                    w_multi;
  logic [CHIP_W-1:0]       w_lo_chip;
  chip_op_e                w_instr_op;
  chip_op_e                w_op [NCHIP];
  logic [PAGE_W+COL_W-1:0] w_chip_addr [NCHIP];
  logic [PAGE_W+COL_W-1:0] w_sel_addr;
  logic                    w_we;
  logic [ADDR_W-1:0]       w_waddr;
  logic [7:0]              w_wdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_db   <= '0;
      r_dori <= 1'b0;
      r_cs   <= '0;
      r_en   <= 1'b0;
      r_en_d <= 1'b0;
      r_rw   <= 1'b0;
      r_rst  <= 1'b0;
    end else begin
      r_db   <= db_i;
      r_dori <= dori_i;
      r_cs   <= cs_i;
      r_en   <= en_i;
      r_en_d <= r_en;
      r_rw   <= rw_i;
      r_rst  <= rst_i;
    end
  end

  assign w_commit   = r_en & ~r_en_d;
  assign w_run      = (r_state == ST_RUN);
  // A transfer that actually touches chip state or RAM.
  assign w_live     = w_commit & ~r_rst & w_run & (|r_cs) & ~r_rw;
  assign w_multi    = ($countones(r_cs) > 1);
  assign w_instr_op = decode_instr(r_db);

  always_comb begin
    w_lo_chip = '0;
    for (int i = NCHIP - 1; i >= 0; i--) begin
      if (r_cs[i]) w_lo_chip = CHIP_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NCHIP; i++) begin
      w_op[i] = OP_NONE;
      if (w_live) begin
        if (r_dori) begin
          if (w_lo_chip == CHIP_W'(i)) w_op[i] = OP_INC;
        end else if (r_cs[i]) begin
          w_op[i] = w_instr_op;
        end
      end
    end
  end

  for (genvar g = 0; g < NCHIP; g++) begin : g_chip
    lcd_chip_regs u_regs (
      .clk          (clk),
      .rstn         (rstn),
      .i_rst        (r_rst),
      .i_op         (w_op[g]),
      .i_arg        (r_db[COL_W-1:0]),
      .o_disp_on    (disp_on_o[g]),
      .o_start_line (start_line_o[g*COL_W +: COL_W]),
      .o_wr_addr    (w_chip_addr[g])
    );
  end

  assign w_sel_addr = w_chip_addr[w_lo_chip];

  // The chip's Y advances on the same edge, so the write uses the pre-increment address.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_addr;
    w_wdata = CLEAR_VAL;
    if (rstn) begin
      if (!w_run) begin
        w_we = 1'b1;
      end else if (w_live && r_dori) begin
        w_we    = 1'b1;
        w_waddr = pack_addr(w_lo_chip, w_sel_addr[PAGE_W+COL_W-1:COL_W], w_sel_addr[COL_W-1:0]);
        w_wdata = r_db;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_rd_data <= '0;
    else       r_rd_data <= r_mem[rd_addr_i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_busy     <= CLEAR_ON_RESET;
      r_clr_addr <= '0;
      r_err      <= 1'b0;
      r_show     <= 1'b0;
    end else begin
      r_show <= w_live & ~r_dori & (w_instr_op == OP_DISP) & r_db[0];
      if (w_commit && !r_rst && (!w_run || ((|r_cs) && (r_rw || (r_dori && w_multi)))))
        r_err <= 1'b1;
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (&r_clr_addr) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign rd_data_o = r_rd_data;
  assign busy_o    = r_busy;
  assign err_o     = r_err;
  assign show_o    = r_show;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed vector table, hand sequences, and random traffic
// checked against a behavioural panel model.
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  db_i = '0;
  logic        dori_i = 1'b0;
  logic [3:0]  cs_i = '0;
  logic        en_i = 1'b0;
  logic        rw_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [10:0] rd_addr_i = '0;
  logic [7:0]  rd_data_o;
  logic [3:0]  disp_on_o;
  logic [23:0] start_line_o;
  logic        busy_o;
  logic        err_o;
  logic        show_o;

  lcd_bus_receiver dut (
    .clk          (clk),
    .rstn         (rstn),
    .db_i         (db_i),
    .dori_i       (dori_i),
    .cs_i         (cs_i),
    .en_i         (en_i),
    .rw_i         (rw_i),
    .rst_i        (rst_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .disp_on_o    (disp_on_o),
    .start_line_o (start_line_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .show_o       (show_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int show_seen = 0;
  int m_show = 0;

  logic [7:0] m_ram [2048];
  logic [7:0] img [2048];
  int m_y [4];
  int m_page [4];
  int m_start [4];
  bit m_disp [4];
  bit m_err;
  bit m_busy;

  always @(negedge clk) if (show_o === 1'b1) show_seen++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int a = 0; a < 2048; a++) m_ram[a] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m_y[i] = 0; m_page[i] = 0; m_start[i] = 0; m_disp[i] = 1'b0;
    end
    m_err = 1'b0;
    m_busy = 1'b1;
  endfunction

  function automatic void model_apply(input logic d, input logic rw, input logic [3:0] cs,
                                      input logic [7:0] db, input logic rst);
    int c;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_y[i] = 0; m_page[i] = 0; m_start[i] = 0; m_disp[i] = 1'b0;
      end
      return;
    end
    if (m_busy) begin m_err = 1'b1; return; end
    if (cs == 4'b0000) return;
    if (rw) begin m_err = 1'b1; return; end
    if (d) begin
      c = 0;
      for (int i = 3; i >= 0; i--) if (cs[i]) c = i;
      if ($countones(cs) > 1) m_err = 1'b1;
      m_ram[c * 512 + m_page[c] * 64 + m_y[c]] = db;
      m_y[c] = (m_y[c] + 1) % 64;
    end else begin
      if (db[7:1] == 7'b0011111 && db[0]) m_show++;
      for (int i = 0; i < 4; i++) begin
        if (cs[i]) begin
          if (db[7:1] == 7'b0011111)    m_disp[i] = db[0];
          else if (db[7:6] == 2'b01)    m_y[i] = int'(db[5:0]);
          else if (db[7:3] == 5'b10111) m_page[i] = int'(db[2:0]);
          else if (db[7:6] == 2'b11)    m_start[i] = int'(db[5:0]);
        end
      end
    end
  endfunction

  function automatic logic [23:0] m_start_vec();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*6 +: 6] = 6'(m_start[i]);
    return v;
  endfunction

  function automatic logic [3:0] m_disp_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_disp[i];
    return v;
  endfunction

  task automatic xfer(input logic d, input logic rw, input logic [3:0] cs,
                      input logic [7:0] db, input logic rst);
    @(negedge clk);
    db_i = db; dori_i = d; cs_i = cs; rw_i = rw; rst_i = rst; en_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en_i = 1'b0; rst_i = 1'b0;
    @(negedge clk);
    model_apply(d, rw, cs, db, rst);
  endtask

  task automatic rd(input logic [10:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr_i = a;
    @(negedge clk);
    v = rd_data_o;
  endtask

  task automatic sweep(input string name, input bit use_img);
    logic [7:0] v;
    for (int a = 0; a < 2048; a++) begin
      rd(11'(a), v);
      chk($sformatf("%s[%0h]", name, a), v, use_img ? img[a] : m_ram[a]);
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_disp"}, disp_on_o, m_disp_vec());
    chk({name, "_start"}, start_line_o, m_start_vec());
    chk({name, "_err"}, err_o, m_err);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 2048);
    m_busy = 1'b0;
  endtask

  typedef struct packed {
    logic        d;
    logic        rw;
    logic [3:0]  cs;
    logic [7:0]  db;
    logic        rst;
    logic [10:0] ra;
    logic [7:0]  exp_rd;
    logic [3:0]  exp_disp;
    logic [23:0] exp_start;
    logic        exp_err;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [7:0] v;
    logic       rd_, rrw, rrs;
    logic [3:0] rcs;
    logic [7:0] rdb;
    int         idx;

    tbl[0]  = '{1'b0, 1'b0, 4'h1, 8'h3E, 1'b0, 11'h000, 8'h00, 4'h0, 24'h000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'h1, 8'h45, 1'b0, 11'h000, 8'h00, 4'h0, 24'h000000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'h1, 8'hBA, 1'b0, 11'h085, 8'h00, 4'h0, 24'h000000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'h1, 8'hA5, 1'b0, 11'h085, 8'hA5, 4'h0, 24'h000000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'h1, 8'h3C, 1'b0, 11'h086, 8'h3C, 4'h0, 24'h000000, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'h8, 8'h7F, 1'b0, 11'h63F, 8'h00, 4'h0, 24'h000000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'h8, 8'h11, 1'b0, 11'h63F, 8'h11, 4'h0, 24'h000000, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'h8, 8'h22, 1'b0, 11'h600, 8'h22, 4'h0, 24'h000000, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h3, 8'hC5, 1'b0, 11'h63F, 8'h11, 4'h0, 24'h000145, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h5, 8'h3F, 1'b0, 11'h600, 8'h22, 4'h5, 24'h000145, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 8'h00, 1'b0, 11'h000, 8'h00, 4'h5, 24'h000145, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 8'h77, 1'b0, 11'h087, 8'h00, 4'h5, 24'h000145, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'h6, 8'h5A, 1'b0, 11'h200, 8'h5A, 4'h5, 24'h000145, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 4'h4, 8'h6B, 1'b0, 11'h400, 8'h6B, 4'h5, 24'h000145, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 4'h4, 8'h3D, 1'b0, 11'h401, 8'h3D, 4'h5, 24'h000145, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 4'h4, 8'hEE, 1'b1, 11'h401, 8'h3D, 4'h0, 24'h000000, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 4'h4, 8'h4C, 1'b0, 11'h400, 8'h4C, 4'h0, 24'h000000, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 11'h402, 8'h00, 4'h0, 24'h000000, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 4'h1, 8'h81, 1'b0, 11'h000, 8'h81, 4'h0, 24'h000000, 1'b1};

    repeat (2) @(negedge clk);
    pulse_reset();
    chk("rst_rd_data", rd_data_o, 8'h00);
    chk("rst_disp", disp_on_o, 4'h0);
    chk("rst_start", start_line_o, 24'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_show", show_o, 1'b0);
    chk("rst_busy", busy_o, 1'b1);
    wait_clear("busy_len_first");
    sweep("clear_rd", 1'b0);

    for (int i = 0; i < 19; i++) begin
      xfer(tbl[i].d, tbl[i].rw, tbl[i].cs, tbl[i].db, tbl[i].rst);
      rd(tbl[i].ra, v);
      chk($sformatf("vec%0d_rd", i), v, tbl[i].exp_rd);
      chk($sformatf("vec%0d_disp", i), disp_on_o, tbl[i].exp_disp);
      chk($sformatf("vec%0d_start", i), start_line_o, tbl[i].exp_start);
      chk($sformatf("vec%0d_err", i), err_o, tbl[i].exp_err);
    end
    chk("vec_show_count", show_seen, 1);

    // Write and read the same address on one edge: old byte first, new byte next cycle.
    @(negedge clk);
    rd_addr_i = 11'h001;
    db_i = 8'hC3; dori_i = 1'b1; cs_i = 4'b0001; rw_i = 1'b0; rst_i = 1'b0; en_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("collide_old", rd_data_o, 8'h00);
    en_i = 1'b0;
    @(negedge clk);
    chk("collide_new", rd_data_o, 8'hC3);
    model_apply(1'b1, 1'b0, 4'b0001, 8'hC3, 1'b0);

    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 8; p++) begin
        xfer(1'b0, 1'b0, 4'(1 << c), {5'b10111, 3'(p)}, 1'b0);
        xfer(1'b0, 1'b0, 4'(1 << c), 8'h40, 1'b0);
        for (int col = 0; col < 64; col++) begin
          idx = c * 512 + p * 64 + col;
          img[idx] = 8'($urandom);
          xfer(1'b1, 1'b0, 4'(1 << c), img[idx], 1'b0);
        end
      end
    end
    xfer(1'b0, 1'b0, 4'hF, 8'h3F, 1'b0);
    chk("frame_disp", disp_on_o, 4'hF);
    chk("frame_show_count", show_seen, 2);
    sweep("frame_rd", 1'b1);

    for (int k = 0; k < 400; k++) begin
      rd_ = 1'($urandom_range(0, 1));
      rrw = ($urandom_range(0, 15) == 0);
      rrs = ($urandom_range(0, 31) == 0);
      rcs = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      if (rd_) rdb = 8'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0:       rdb = {7'b0011111, 1'($urandom_range(0, 1))};
          1:       rdb = {2'b01, 6'($urandom)};
          2:       rdb = {5'b10111, 3'($urandom)};
          3:       rdb = {2'b11, 6'($urandom)};
          default: rdb = 8'($urandom);
        endcase
      end
      xfer(rd_, rrw, rcs, rdb, rrs);
      check_state($sformatf("rand%0d", k));
    end
    chk("rand_show_count", show_seen, m_show);
    sweep("rand_rd", 1'b0);

    pulse_reset();
    wait_clear("busy_len_second");
    xfer(1'b1, 1'b1, 4'b0001, 8'h99, 1'b0);
    chk("rw_err", err_o, 1'b1);
    rd(11'h000, v);
    chk("rw_no_write", v, 8'h00);
    xfer(1'b1, 1'b0, 4'b0001, 8'h12, 1'b0);
    rd(11'h000, v);
    chk("rw_y_kept", v, 8'h12);

    pulse_reset();
    xfer(1'b1, 1'b0, 4'b0001, 8'hAA, 1'b0);
    chk("clear_xfer_err", err_o, 1'b1);
    chk("clear_busy_mid", busy_o, 1'b1);
    repeat (100) @(negedge clk);
    pulse_reset();
    chk("err_cleared", err_o, 1'b0);
    wait_clear("busy_len_restart");
    rd(11'h000, v);
    chk("restart_rd0", v, 8'h00);
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
